trb_mem_scheduler: RTL and testbench
====================================

Name: trb_mem_scheduler

Overview:
- Owns the single-port trace RAM and time-multiplexes it between the Logger (trace write/read) and a host readout port.
- Generates the Logger's RW_TURN_I, WRITE_ALLOW_I and READ_ALLOW_I from a 3-phase slot schedule.
- Suspends the Logger and grants exclusive RAM access to the host on request.
- Sits between the Logger, the system interface readout path and the RAM macro (1-cycle synchronous read latency).

Parameters:
- ADDR_WIDTH, default TRB_ADDR_WIDTH: RAM address width.
- DATA_WIDTH, default TRB_WIDTH: RAM word width.

Ports:
- CLK_I  in  1  clock; single clock domain.
- RST_I  in  1  reset; asynchronous, active-high.
- RW_TURN_O  out  1  write slot strobe to Logger.
- WRITE_ALLOW_O  out  1  Logger may write.
- READ_ALLOW_O  out  1  Logger read data valid this cycle.
- LOG_WRITE_I  in  1  Logger write intent (WRITE_O).
- LOG_WPTR_I  in  ADDR_WIDTH  Logger write pointer.
- LOG_WDATA_I  in  DATA_WIDTH  Logger write data.
- LOG_RPTR_I  in  ADDR_WIDTH  Logger read pointer.
- LOG_RDATA_O  out  DATA_WIDTH  read data to Logger (DMEM_I).
- HOST_REQ_I  in  1  level request for exclusive access.
- HOST_GNT_O  out  1  exclusive access granted.
- HOST_VALID_I  in  1  host access strobe.
- HOST_WE_I  in  1  1 = write, 0 = read.
- HOST_ADDR_I  in  ADDR_WIDTH  host address.
- HOST_WDATA_I  in  DATA_WIDTH  host write data.
- HOST_RDATA_O  out  DATA_WIDTH  host read data.
- HOST_RVALID_O  out  1  HOST_RDATA_O valid.
- MEM_EN_O  out  1  RAM enable.
- MEM_WE_O  out  1  RAM write enable.
- MEM_ADDR_O  out  ADDR_WIDTH  RAM address.
- MEM_WDATA_O  out  DATA_WIDTH  RAM write data.
- MEM_RDATA_I  in  DATA_WIDTH  RAM read data, 1 cycle after address.

Behaviour:
- Reset (async, RST_I=1): state IDLE, phase W, HOST_RVALID_O=0. While in IDLE all control outputs are 0; data outputs follow the rules below.
- States: IDLE, LOG, DRAIN, HOST, RELEASE.
  - IDLE -> LOG on the first edge after reset deassertion, entering phase W.
- Phase counter: cycles W -> A -> R -> W while in LOG/DRAIN; otherwise held at W.
- Phase W: RW_TURN_O=1.
  - If LOG_WRITE_I=1: MEM_EN=MEM_WE=1, MEM_ADDR=LOG_WPTR_I, MEM_WDATA=LOG_WDATA_I.
- Phase A: RW_TURN_O=0, READ_ALLOW_O=0; MEM_EN=1, MEM_WE=0, MEM_ADDR=LOG_RPTR_I.
- Phase R: RW_TURN_O=0, READ_ALLOW_O=1, no RAM access. LOG_RDATA_O carries data for the pointer presented in A.
  - The Logger advances its read pointer only at the end of R, so A/R data is always coherent.
- WRITE_ALLOW_O=1 in LOG and DRAIN.
- READ_ALLOW_O=1 only in phase R of LOG/DRAIN.
- LOG_RDATA_O = MEM_RDATA_I combinationally. HOST_RDATA_O = MEM_RDATA_I combinationally.
- RAM outputs are don't-care whenever MEM_EN_O=0; MEM_WDATA_O is 0 then.
- Host handshake:
  - LOG with HOST_REQ_I=1 -> DRAIN. DRAIN completes the current W/A/R round and moves to HOST at the edge leaving R.
  - Worst-case grant latency: 3 cycles.
  - HOST_REQ_I dropped during DRAIN -> return to LOG at the next W; no grant is issued.
- HOST: HOST_GNT_O=1; RW_TURN_O=0; WRITE_ALLOW_O=0; READ_ALLOW_O=0.
  - HOST_VALID_I=1 drives the RAM directly: MEM_EN=1, MEM_WE=HOST_WE_I, address and data from host.
  - A read sets HOST_RVALID_O=1 on the following cycle, for exactly 1 cycle.
  - One access per cycle; back-to-back reads are supported.
- HOST with HOST_REQ_I=0 -> RELEASE, with HOST_GNT_O=0 from that cycle.
  - HOST_VALID_I without a grant is ignored.
  - RELEASE lasts 1 cycle so a read issued in the last HOST cycle returns with HOST_RVALID_O. Then -> LOG, phase W.
- Logger pending write/read requests survive a host period untouched; allow signals are 0, so the Logger keeps them pending.
- Reset mid-operation: immediate grant loss, all strobes 0, in-flight host read is dropped (no RVALID).

Decomposition:
- DTB_PKG gains:
  - enum sched_state_t {IDLE, LOG, DRAIN, HOST, RELEASE};
  - enum sched_phase_t {PH_W, PH_A, PH_R}.
- Width defaults reuse TRB_ADDR_WIDTH and TRB_WIDTH.
- One natural sub-module: trb_phase_gen, the 3-phase counter with hold/restart inputs.
- The RAM mux and the FSM stay in the top module.

Test Plan:
- Reset release, no requests -> RW_TURN_O pattern 1,0,0 repeating from the first cycle after reset; READ_ALLOW_O=1 every third cycle aligned with R; MEM_WE_O=0.
- LOG_WRITE_I=1 in W with WPTR=5, WDATA=0xA5 -> MEM_EN=MEM_WE=1, ADDR=5, WDATA=0xA5. Then RPTR=5 in the next A -> LOG_RDATA_O=0xA5 with READ_ALLOW_O=1 in R.
- HOST_REQ_I asserted in phase A -> HOST_GNT_O rises 2 cycles later (after R); WRITE_ALLOW_O and READ_ALLOW_O are 0 throughout the grant.
- In HOST: write 0x3C to addr 7, then read addr 7 -> HOST_RVALID_O=1 with HOST_RDATA_O=0x3C exactly 1 cycle after the read.
- Read issued in the last HOST cycle, then HOST_REQ_I=0 -> RVALID returned during RELEASE; RW_TURN_O=1 on the next cycle.
- HOST_REQ_I pulsed for 1 cycle in W -> DRAIN, no grant, LOG resumes with uninterrupted W/A/R.
- RST_I asserted mid-HOST -> HOST_GNT_O and all strobes 0 asynchronously; no HOST_RVALID_O.

Source files
------------

// File: rtl/trb_mem_scheduler_pkg.sv
// Shared types and width defaults for the trace RAM scheduler.
// The phase helper is the single definition of the W -> A -> R rotation.
package trb_mem_scheduler_pkg;

  localparam int TRB_ADDR_WIDTH = 8;
  localparam int TRB_WIDTH      = 16;

  typedef enum logic [2:0] {IDLE, LOG, DRAIN, HOST, RELEASE} sched_state_t;
  typedef enum logic [1:0] {PH_W, PH_A, PH_R} sched_phase_t;

  function automatic sched_phase_t next_phase(input sched_phase_t p);
    case (p)
      PH_W:    return PH_A;
      PH_A:    return PH_R;
      default: return PH_W;
    endcase
  endfunction

endpackage

// File: rtl/trb_phase_gen.sv
// Three-phase slot counter (W, A, R). Advances while run_i is high,
// and is forced back to W whenever restart_i is high.
module trb_phase_gen
  import trb_mem_scheduler_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       run_i,
  input  logic       restart_i,
  output logic [1:0] phase_o
);

  sched_phase_t phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (restart_i) begin
      phase_d = PH_W;
    end else if (run_i) begin
      phase_d = next_phase(phase_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q <= PH_W;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/trb_mem_scheduler.sv
// Time-multiplexes the single-port trace RAM between the Logger slot
// schedule and an exclusive host access window.
module trb_mem_scheduler
  import trb_mem_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH = TRB_ADDR_WIDTH,
  parameter int DATA_WIDTH = TRB_WIDTH
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  output logic                  RW_TURN_O,
  output logic                  WRITE_ALLOW_O,
  output logic                  READ_ALLOW_O,
  input  logic                  LOG_WRITE_I,
  input  logic [ADDR_WIDTH-1:0] LOG_WPTR_I,
  input  logic [DATA_WIDTH-1:0] LOG_WDATA_I,
  input  logic [ADDR_WIDTH-1:0] LOG_RPTR_I,
  output logic [DATA_WIDTH-1:0] LOG_RDATA_O,
  input  logic                  HOST_REQ_I,
  output logic                  HOST_GNT_O,
  input  logic                  HOST_VALID_I,
  input  logic                  HOST_WE_I,
  input  logic [ADDR_WIDTH-1:0] HOST_ADDR_I,
  input  logic [DATA_WIDTH-1:0] HOST_WDATA_I,
  output logic [DATA_WIDTH-1:0] HOST_RDATA_O,
  output logic                  HOST_RVALID_O,
  output logic                  MEM_EN_O,
  output logic                  MEM_WE_O,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR_O,
  output logic [DATA_WIDTH-1:0] MEM_WDATA_O,
  input  logic [DATA_WIDTH-1:0] MEM_RDATA_I
);

  sched_state_t state_q, state_d;
  sched_phase_t phase;
  logic [1:0]   phase_raw;
  logic         run;
  logic         rvalid_q, rvalid_d;

  assign run   = (state_q == LOG) || (state_q == DRAIN);
  assign phase = sched_phase_t'(phase_raw);

  trb_phase_gen u_phase_gen (
    .clk_i     (CLK_I),
    .rst_i     (RST_I),
    .run_i     (run),
    .restart_i (!run),
    .phase_o   (phase_raw)
  );

  // A request seen at the end of R grants immediately, which bounds the
  // grant latency to three cycles when the request arrives in W.
  always_comb begin
    state_d       = state_q;
    rvalid_d      = 1'b0;
    RW_TURN_O     = 1'b0;
    WRITE_ALLOW_O = 1'b0;
    READ_ALLOW_O  = 1'b0;
    HOST_GNT_O    = 1'b0;
    MEM_EN_O      = 1'b0;
    MEM_WE_O      = 1'b0;
    MEM_ADDR_O    = '0;
    MEM_WDATA_O   = '0;
    case (state_q)
      IDLE: begin
        state_d = LOG;
      end
      LOG, DRAIN: begin
        if (phase == PH_R) begin
          state_d = HOST_REQ_I ? HOST : LOG;
        end else begin
          state_d = HOST_REQ_I ? DRAIN : LOG;
        end
        WRITE_ALLOW_O = 1'b1;
        case (phase)
          PH_W: begin
            RW_TURN_O = 1'b1;
            if (LOG_WRITE_I) begin
              MEM_EN_O    = 1'b1;
              MEM_WE_O    = 1'b1;
              MEM_ADDR_O  = LOG_WPTR_I;
              MEM_WDATA_O = LOG_WDATA_I;
            end
          end
          PH_A: begin
            MEM_EN_O   = 1'b1;
            MEM_ADDR_O = LOG_RPTR_I;
          end
          default: begin
            READ_ALLOW_O = 1'b1;
          end
        endcase
      end
      HOST: begin
        if (!HOST_REQ_I) begin
          state_d = RELEASE;
        end
        HOST_GNT_O = 1'b1;
        if (HOST_VALID_I) begin
          MEM_EN_O    = 1'b1;
          MEM_WE_O    = HOST_WE_I;
          MEM_ADDR_O  = HOST_ADDR_I;
          MEM_WDATA_O = HOST_WDATA_I;
          rvalid_d    = !HOST_WE_I;
        end
      end
      RELEASE: begin
        state_d = LOG;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q  <= IDLE;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign HOST_RVALID_O = rvalid_q;
  assign LOG_RDATA_O   = MEM_RDATA_I;
  assign HOST_RDATA_O  = MEM_RDATA_I;

endmodule

// File: tb/tb_trb_mem_scheduler.sv
// Randomized bench for trb_mem_scheduler: a slot/grant reference model plus
// a RAM model, compared every cycle, with directed literal scenarios first.
module tb_trb_mem_scheduler;
  import trb_mem_scheduler_pkg::*;

  localparam int AW    = TRB_ADDR_WIDTH;
  localparam int DW    = TRB_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam int M_IDLE = 0, M_RUN = 1, M_HOST = 2, M_REL = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rw_turn, write_allow, read_allow;
  logic          log_write = 1'b0;
  logic [AW-1:0] log_wptr = '0, log_rptr = '0;
  logic [DW-1:0] log_wdata = '0, log_rdata;
  logic          host_req = 1'b0, host_gnt;
  logic          host_valid = 1'b0, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0, host_rdata;
  logic          host_rvalid;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] ram_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  trb_mem_scheduler dut (
    .CLK_I(clk), .RST_I(rst),
    .RW_TURN_O(rw_turn), .WRITE_ALLOW_O(write_allow), .READ_ALLOW_O(read_allow),
    .LOG_WRITE_I(log_write), .LOG_WPTR_I(log_wptr), .LOG_WDATA_I(log_wdata),
    .LOG_RPTR_I(log_rptr), .LOG_RDATA_O(log_rdata),
    .HOST_REQ_I(host_req), .HOST_GNT_O(host_gnt),
    .HOST_VALID_I(host_valid), .HOST_WE_I(host_we), .HOST_ADDR_I(host_addr),
    .HOST_WDATA_I(host_wdata), .HOST_RDATA_O(host_rdata), .HOST_RVALID_O(host_rvalid),
    .MEM_EN_O(mem_en), .MEM_WE_O(mem_we), .MEM_ADDR_O(mem_addr),
    .MEM_WDATA_O(mem_wdata), .MEM_RDATA_I(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM macro with one cycle of read latency
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: current cycle state, updated at the clock edge
  logic [DW-1:0] m_mem [DEPTH];
  int            m_mode = M_IDLE, m_ph = 0;
  bit            m_rv = 1'b0;
  logic [DW-1:0] m_rv_data = '0, m_rd_data = '0;
  int            n_mode = M_IDLE, n_ph = 0;
  bit            n_rv = 1'b0, n_wr = 1'b0;
  logic [DW-1:0] n_rv_data = '0, n_rd_data = '0, n_wdata = '0;
  logic [AW-1:0] n_waddr = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_IDLE;
      m_ph   = 0;
      m_rv   = 1'b0;
    end else begin
      if (n_wr) m_mem[n_waddr] = n_wdata;
      m_mode    = n_mode;
      m_ph      = n_ph;
      m_rv      = n_rv;
      m_rv_data = n_rv_data;
      m_rd_data = n_rd_data;
    end
  end

  always @(negedge clk) begin
    logic          e_rw, e_wa, e_ra, e_gnt, e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    e_rw = 0; e_wa = 0; e_ra = 0; e_gnt = 0; e_en = 0; e_we = 0;
    e_addr = '0; e_wd = '0;
    if (m_mode == M_RUN) begin
      e_rw = (m_ph == 0);
      e_wa = 1'b1;
      e_ra = (m_ph == 2);
      if (m_ph == 0 && log_write) begin
        e_en = 1; e_we = 1; e_addr = log_wptr; e_wd = log_wdata;
      end else if (m_ph == 1) begin
        e_en = 1; e_addr = log_rptr;
      end
    end else if (m_mode == M_HOST) begin
      e_gnt = 1'b1;
      if (host_valid) begin
        e_en = 1; e_we = host_we; e_addr = host_addr; e_wd = host_wdata;
      end
    end
    chk("rw_turn", rw_turn, e_rw);
    chk("write_allow", write_allow, e_wa);
    chk("read_allow", read_allow, e_ra);
    chk("host_gnt", host_gnt, e_gnt);
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    if (e_en) chk("mem_addr", mem_addr, e_addr);
    if (!e_en || e_we) chk("mem_wdata", mem_wdata, e_wd);
    if (m_mode == M_RUN && m_ph == 2) chk("log_rdata", log_rdata, m_rd_data);
    chk("host_rvalid", host_rvalid, m_rv);
    if (m_rv) chk("host_rdata", host_rdata, m_rv_data);

    n_wr = !rst && e_en && e_we;
    n_waddr = e_addr;
    n_wdata = e_wd;
    n_rv = !rst && m_mode == M_HOST && host_valid && !host_we;
    n_rv_data = m_mem[host_addr];
    n_rd_data = (m_mode == M_RUN && m_ph == 1) ? m_mem[log_rptr] : m_rd_data;
    n_ph = 0;
    case (m_mode)
      M_IDLE: n_mode = M_RUN;
      M_RUN: begin
        if (m_ph == 2) n_mode = host_req ? M_HOST : M_RUN;
        else begin
          n_mode = M_RUN;
          n_ph   = m_ph + 1;
        end
      end
      M_HOST:  n_mode = host_req ? M_HOST : M_REL;
      default: n_mode = M_RUN;
    endcase
    if (rst) n_mode = M_IDLE;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input int p);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      step();
      ok = (m_mode == M_RUN && m_ph == p);
    end
    chk("wait_phase", ok, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit got;
    for (int i = 0; i < DEPTH; i++) begin
      logic [DW-1:0] v;
      v = DW'($urandom);
      ram[i]   = v;
      m_mem[i] = v;
    end
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rw_turn", rw_turn, 1'b0);
    chk("idle_write_allow", write_allow, 1'b0);

    // Slot rotation from the first LOG cycle
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("pattern_rw_turn", rw_turn, (k % 3) == 0);
      chk("pattern_read_allow", read_allow, (k % 3) == 2);
      chk("pattern_mem_we", mem_we, 1'b0);
    end

    // Logger write then read-back through A/R
    wait_phase(0);
    log_write = 1'b1; log_wptr = AW'(5); log_wdata = DW'('hA5);
    @(negedge clk);
    chk("lw_mem_en", mem_en, 1'b1);
    chk("lw_mem_we", mem_we, 1'b1);
    chk("lw_mem_addr", mem_addr, 5);
    chk("lw_mem_wdata", mem_wdata, 'hA5);
    step();
    log_write = 1'b0; log_rptr = AW'(5);
    @(negedge clk);
    chk("la_mem_en", mem_en, 1'b1);
    chk("la_mem_addr", mem_addr, 5);
    step();
    @(negedge clk);
    chk("lr_read_allow", read_allow, 1'b1);
    chk("lr_log_rdata", log_rdata, 'hA5);

    // Request in A: grant two cycles later
    wait_phase(1);
    host_req = 1'b1;
    @(negedge clk);
    chk("req_a_gnt0", host_gnt, 1'b0);
    step();
    @(negedge clk);
    chk("req_r_gnt0", host_gnt, 1'b0);
    step();
    @(negedge clk);
    chk("host_gnt1", host_gnt, 1'b1);
    chk("host_write_allow", write_allow, 1'b0);
    chk("host_read_allow", read_allow, 1'b0);

    // Host write then read of address 7
    step();
    host_valid = 1'b1; host_we = 1'b1; host_addr = AW'(7); host_wdata = DW'('h3C);
    step();
    host_we = 1'b0;
    step();
    host_valid = 1'b0;
    @(negedge clk);
    chk("host_rvalid", host_rvalid, 1'b1);
    chk("host_rdata", host_rdata, 'h3C);

    // Read in the last HOST cycle returns during RELEASE
    step();
    host_valid = 1'b1; host_we = 1'b0; host_addr = AW'(5); host_req = 1'b0;
    @(negedge clk);
    chk("last_host_gnt", host_gnt, 1'b1);
    step();
    host_valid = 1'b1; host_we = 1'b1; host_addr = AW'(9);
    @(negedge clk);
    chk("rel_gnt", host_gnt, 1'b0);
    chk("rel_rvalid", host_rvalid, 1'b1);
    chk("rel_rdata", host_rdata, 'hA5);
    chk("rel_mem_en", mem_en, 1'b0);
    chk("rel_rw_turn", rw_turn, 1'b0);
    step();
    host_valid = 1'b0; host_we = 1'b0;
    @(negedge clk);
    chk("after_rel_rw_turn", rw_turn, 1'b1);

    // One-cycle request pulse in W: no grant, rotation continues
    wait_phase(0);
    host_req = 1'b1;
    @(negedge clk);
    chk("pulse_rw_turn", rw_turn, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      step();
      host_req = 1'b0;
      @(negedge clk);
      chk("pulse_rw_turn", rw_turn, (k % 3) == 0);
      chk("pulse_gnt", host_gnt, 1'b0);
    end

    // Reset in the middle of a host read
    wait_phase(1);
    host_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = host_gnt;
    end
    chk("gnt_wait", got, 1'b1);
    step();
    host_valid = 1'b1; host_we = 1'b0; host_addr = AW'(7);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_gnt", host_gnt, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_rw_turn", rw_turn, 1'b0);
    step();
    @(negedge clk);
    chk("rst_rvalid", host_rvalid, 1'b0);
    step();
    host_valid = 1'b0; host_req = 1'b0; rst = 1'b0;

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      step();
      log_write  = $urandom_range(0, 1);
      log_wptr   = AW'($urandom_range(0, 15));
      log_wdata  = DW'($urandom);
      log_rptr   = AW'($urandom_range(0, 15));
      host_valid = $urandom_range(0, 2) != 0;
      host_we    = $urandom_range(0, 1);
      host_addr  = AW'($urandom_range(0, 15));
      host_wdata = DW'($urandom);
      if ($urandom_range(0, 5) == 0) host_req = !host_req;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 399) == 0) rst = 1'b1;
    end
    step();
    rst = 1'b0; host_req = 1'b0; host_valid = 1'b0; log_write = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
